// File: rtl/kernel_engine_sync.sv
// kernel_engine_sync: sends engine setup to every engine and gathers the
// completion pulses from all engines. It returns setup/done to the kernel
// control FSM. Every output is a register, and no input reaches an output
// through combinational logic alone.
module kernel_engine_sync #(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                   ap_clk,
    input  logic                   areset_n,
    input  logic                   ctrl_start,
    input  logic                   descriptor_valid,
    input  logic [CNT_W-1:0]       num_items,
    output logic [NUM_ENGINES-1:0] engine_setup_req,
    input  logic [NUM_ENGINES-1:0] engine_setup_ack,
    input  logic [NUM_ENGINES-1:0] engine_done_item,
    output logic                   setup,
    output logic                   done,
    output logic [CNT_W-1:0]       items_done,
    output logic                   error_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StArmed,
        StRun,
        StDone,
        StError
    } state_e;

    localparam logic [NUM_ENGINES-1:0] AllEngines = '1;
    localparam logic [TIMEOUT_W-1:0]   TimeoutMax = '1;

    state_e                 state_q, state_d;
    logic                   ctrl_start_q;
    logic                   start_rise;

    logic [NUM_ENGINES-1:0] ack_mask_q, ack_mask_d;
    logic [NUM_ENGINES-1:0] ack_mask_next;
    logic [TIMEOUT_W-1:0]   timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0]   timeout_inc;

    logic [CNT_W-1:0]       target_q, target_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       item_pop;
    logic [CNT_W:0]         count_sum;
    logic [CNT_W-1:0]       count_sat;

    logic [NUM_ENGINES-1:0] req_q, req_d;
    logic                   setup_q, setup_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    assign start_rise    = ctrl_start & ~ctrl_start_q;
    assign ack_mask_next = ack_mask_q | engine_setup_ack;
    assign timeout_inc   = timeout_q + TIMEOUT_W'(1);

    // Count the completion pulses in this cycle. The sum has one extra bit, so
    // carry-out into that bit still compares correctly against the target.
    always_comb begin
        item_pop = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            item_pop = item_pop + CNT_W'(engine_done_item[i]);
        end
        count_sum = {1'b0, count_q} + {1'b0, item_pop};
        if (count_sum >= {1'b0, target_q}) begin
            count_sat = target_q;
        end else begin
            count_sat = count_sum[CNT_W-1:0];
        end
    end

    // State register, plus the delayed start used for edge detection
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= StIdle;
            ctrl_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_start_q <= ctrl_start;
        end
    end

    // Next-state logic. A dropped control level (abort) wins over progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_rise) state_d = StSetup;
            end
            StSetup: begin
                if (!ctrl_start) begin
                    state_d = StIdle;
                end else if (ack_mask_next == AllEngines) begin
                    state_d = StArmed;
                end else if (timeout_inc == TimeoutMax) begin
                    state_d = StError;
                end
            end
            StArmed: begin
                if (!ctrl_start) begin
                    state_d = StIdle;
                end else if (descriptor_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!descriptor_valid) begin
                    state_d = StIdle;
                end else if (count_sat == target_q) begin
                    state_d = StDone;
                end
            end
            StDone, StError: begin
                if (!ctrl_start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the datapath registers
    always_comb begin
        ack_mask_d = ack_mask_q;
        timeout_d  = timeout_q;
        target_d   = target_q;
        count_d    = count_q;
        req_d      = '0;
        err_d      = err_q;
        setup_d    = (state_q == StArmed) || (state_q == StRun) || (state_q == StDone);
        done_d     = (state_q == StDone);

        case (state_q)
            StIdle: begin
                if (state_d == StSetup) begin
                    req_d      = AllEngines;
                    ack_mask_d = '0;
                    timeout_d  = '0;
                    err_d      = 1'b0;
                end
            end
            StSetup: begin
                ack_mask_d = ack_mask_next;
                timeout_d  = timeout_inc;
                if (state_d == StError) err_d = 1'b1;
            end
            StArmed: begin
                if (state_d == StRun) begin
                    target_d = num_items;
                    count_d  = '0;
                end
            end
            StRun: begin
                // Pulses that arrive in the abort cycle are still counted.
                count_d = count_sat;
            end
            default: ;
        endcase
    end

    // Registers for the outputs and the datapath
    always_ff @(posedge ap_clk or negedge areset_n) begin
        if (!areset_n) begin
            ack_mask_q <= '0;
            timeout_q  <= '0;
            target_q   <= '0;
            count_q    <= '0;
            req_q      <= '0;
            setup_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ack_mask_q <= ack_mask_d;
            timeout_q  <= timeout_d;
            target_q   <= target_d;
            count_q    <= count_d;
            req_q      <= req_d;
            setup_q    <= setup_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign engine_setup_req = req_q;
    assign setup            = setup_q;
    assign done             = done_q;
    assign items_done       = count_q;
    assign error_timeout    = err_q;

    // done is only ever raised together with setup
    a_done_implies_setup: assert property (
        @(posedge ap_clk) disable iff (!areset_n) done_q |-> setup_q);

    // A setup request lasts exactly one cycle
    a_req_single_cycle: assert property (
        @(posedge ap_clk) disable iff (!areset_n) (req_q != '0) |=> (req_q == '0));

endmodule

// File: tb/tb_kernel_engine_sync.sv
// Self-checking bench for kernel_engine_sync. Expected values come from
// arithmetic on the stimulus: popcounts capped at the target, and fixed
// handshake latencies.
module tb_kernel_engine_sync;

    localparam int unsigned NE  = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned TW  = 4;

    logic          ap_clk = 1'b0;
    logic          areset_n;
    logic          ctrl_start;
    logic          descriptor_valid;
    logic [CW-1:0] num_items;
    logic [NE-1:0] engine_setup_req;
    logic [NE-1:0] engine_setup_ack;
    logic [NE-1:0] engine_done_item;
    logic          setup;
    logic          done;
    logic [CW-1:0] items_done;
    logic          error_timeout;

    int n_compared   = 0;
    int n_mismatched = 0;

    kernel_engine_sync #(
        .NUM_ENGINES (NE),
        .CNT_W       (CW),
        .TIMEOUT_W   (TW)
    ) dut (
        .ap_clk           (ap_clk),
        .areset_n         (areset_n),
        .ctrl_start       (ctrl_start),
        .descriptor_valid (descriptor_valid),
        .num_items        (num_items),
        .engine_setup_req (engine_setup_req),
        .engine_setup_ack (engine_setup_ack),
        .engine_done_item (engine_done_item),
        .setup            (setup),
        .done             (done),
        .items_done       (items_done),
        .error_timeout    (error_timeout)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one cycle. Outputs are sampled and inputs are driven 1 ns after the edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic go_idle();
        ctrl_start       = 1'b0;
        descriptor_valid = 1'b0;
        engine_done_item = '0;
        engine_setup_ack = '0;
        tick();
        tick();
    endtask

    // From IDLE: start, every engine acks in the request cycle, wait for setup.
    task automatic bring_up();
        ctrl_start = 1'b1;
        tick();
        engine_setup_ack = '1;
        tick();
        engine_setup_ack = '0;
        tick();
    endtask

    task automatic run_start(input int target);
        num_items        = CW'(target);
        descriptor_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        areset_n         = 1'b0;
        ctrl_start       = 1'b0;
        descriptor_valid = 1'b0;
        num_items        = '0;
        engine_setup_ack = '0;
        engine_done_item = '0;
        #3;
        n_compared++;
        if ({engine_setup_req, setup, done, error_timeout} !== 7'b0) begin
            n_mismatched++;
            $display("FAIL reset_flags: got req=%b setup=%b done=%b err=%b want all 0",
                     engine_setup_req, setup, done, error_timeout);
        end
        n_compared++;
        if (items_done !== '0) begin
            n_mismatched++;
            $display("FAIL reset_items: got %0d want 0", items_done);
        end
        tick();
        tick();
        #2 areset_n = 1'b1;
        tick();
        tick();
        n_compared++;
        if (engine_setup_req !== '0 || setup !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_release: got req=%b setup=%b want 0/0",
                     engine_setup_req, setup);
        end
    endtask

    task automatic test_setup_handshake();
        ctrl_start = 1'b1;
        tick();
        n_compared++;
        if (engine_setup_req !== 4'b1111) begin
            n_mismatched++;
            $display("FAIL setup_req_pulse: got %b want 1111", engine_setup_req);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_compared++;
            if (engine_setup_req !== 4'b0000 || setup !== 1'b0) begin
                n_mismatched++;
                $display("FAIL setup_wait c%0d: got req=%b setup=%b want 0000/0",
                         c, engine_setup_req, setup);
            end
        end
        engine_setup_ack = 4'b1111;
        tick();
        engine_setup_ack = '0;
        n_compared++;
        if (setup !== 1'b0) begin
            n_mismatched++;
            $display("FAIL setup_latency1: got %b want 0", setup);
        end
        tick();
        n_compared++;
        if (setup !== 1'b1) begin
            n_mismatched++;
            $display("FAIL setup_latency2: got %b want 1", setup);
        end
    endtask

    task automatic test_item_count();
        logic [NE-1:0] vecs [3] = '{4'b1111, 4'b1111, 4'b0011};
        int exp_cnt = 0;
        run_start(10);
        n_compared++;
        if (items_done !== 32'd0 || done !== 1'b0) begin
            n_mismatched++;
            $display("FAIL count_entry: got items=%0d done=%b want 0/0", items_done, done);
        end
        for (int i = 0; i < 3; i++) begin
            engine_done_item = vecs[i];
            tick();
            exp_cnt += $countones(vecs[i]);
            n_compared++;
            if (items_done !== CW'(exp_cnt) || done !== 1'b0) begin
                n_mismatched++;
                $display("FAIL count_step%0d: got items=%0d done=%b want %0d/0",
                         i, items_done, done, exp_cnt);
            end
        end
        engine_done_item = '0;
        tick();
        n_compared++;
        if (done !== 1'b1 || setup !== 1'b1) begin
            n_mismatched++;
            $display("FAIL count_done: got done=%b setup=%b want 1/1", done, setup);
        end
        for (int i = 0; i < 3; i++) begin
            engine_done_item = 4'b1111;
            tick();
            n_compared++;
            if (done !== 1'b1 || items_done !== 32'd10) begin
                n_mismatched++;
                $display("FAIL count_hold%0d: got done=%b items=%0d want 1/10",
                         i, done, items_done);
            end
        end
        engine_done_item = '0;
        ctrl_start       = 1'b0;
        descriptor_valid = 1'b0;
        tick();
        n_compared++;
        if (done !== 1'b1) begin
            n_mismatched++;
            $display("FAIL done_drop_delay: got %b want 1", done);
        end
        tick();
        n_compared++;
        if (done !== 1'b0 || setup !== 1'b0) begin
            n_mismatched++;
            $display("FAIL done_dropped: got done=%b setup=%b want 0/0", done, setup);
        end
        tick();
    endtask

    task automatic test_timeout();
        ctrl_start = 1'b1;
        tick();
        engine_setup_ack = 4'b0111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c == 1) engine_setup_ack = '0;
            n_compared++;
            if (error_timeout !== (c == 15) || setup !== 1'b0) begin
                n_mismatched++;
                $display("FAIL timeout_c%0d: got err=%b setup=%b want %b/0",
                         c, error_timeout, setup, c == 15);
            end
        end
        ctrl_start = 1'b0;
        tick();
        tick();
        n_compared++;
        if (error_timeout !== 1'b1) begin
            n_mismatched++;
            $display("FAIL timeout_sticky: got %b want 1", error_timeout);
        end
        ctrl_start = 1'b1;
        tick();
        n_compared++;
        if (error_timeout !== 1'b0 || engine_setup_req !== 4'b1111) begin
            n_mismatched++;
            $display("FAIL timeout_clear: got err=%b req=%b want 0/1111",
                     error_timeout, engine_setup_req);
        end
        engine_setup_ack = 4'b1111;
        tick();
        engine_setup_ack = '0;
        tick();
        n_compared++;
        if (setup !== 1'b1) begin
            n_mismatched++;
            $display("FAIL timeout_rearm: got setup=%b want 1", setup);
        end
        go_idle();
    endtask

    task automatic test_zero_and_saturate();
        logic [NE-1:0] vecs [3] = '{4'b0111, 4'b0111, 4'b0001};
        int exp_cnt = 0;
        bring_up();
        engine_done_item = 4'b1010;
        run_start(0);
        engine_done_item = 4'b1100;
        tick();
        engine_done_item = '0;
        n_compared++;
        if (done !== 1'b0 || items_done !== 32'd0) begin
            n_mismatched++;
            $display("FAIL zero_target1: got done=%b items=%0d want 0/0", done, items_done);
        end
        tick();
        n_compared++;
        if (done !== 1'b1 || items_done !== 32'd0) begin
            n_mismatched++;
            $display("FAIL zero_target2: got done=%b items=%0d want 1/0", done, items_done);
        end
        go_idle();
        bring_up();
        run_start(5);
        for (int i = 0; i < 3; i++) begin
            engine_done_item = vecs[i];
            tick();
            exp_cnt = (exp_cnt + $countones(vecs[i]) > 5) ? 5 : exp_cnt + $countones(vecs[i]);
            n_compared++;
            if (items_done !== CW'(exp_cnt)) begin
                n_mismatched++;
                $display("FAIL saturate%0d: got %0d want %0d", i, items_done, exp_cnt);
            end
        end
        engine_done_item = '0;
        tick();
        n_compared++;
        if (done !== 1'b1 || items_done !== 32'd5) begin
            n_mismatched++;
            $display("FAIL saturate_done: got done=%b items=%0d want 1/5", done, items_done);
        end
        go_idle();
    endtask

    task automatic test_abort_and_reset();
        bring_up();
        run_start(6);
        engine_done_item = 4'b0011;
        tick();
        engine_done_item = 4'b0001;
        tick();
        n_compared++;
        if (items_done !== 32'd3) begin
            n_mismatched++;
            $display("FAIL abort_pre: got %0d want 3", items_done);
        end
        descriptor_valid = 1'b0;
        engine_done_item = 4'b0010;
        tick();
        n_compared++;
        if (items_done !== 32'd4) begin
            n_mismatched++;
            $display("FAIL abort_last_pulse: got %0d want 4", items_done);
        end
        engine_done_item = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_compared++;
            if (done !== 1'b0 || setup !== 1'b0 || items_done !== 32'd4) begin
                n_mismatched++;
                $display("FAIL abort_idle%0d: got done=%b setup=%b items=%0d want 0/0/4",
                         c, done, setup, items_done);
            end
        end
        go_idle();
        bring_up();
        run_start(6);
        engine_done_item = 4'b0001;
        tick();
        engine_done_item = '0;
        #2 areset_n = 1'b0;
        #1;
        n_compared++;
        if ({engine_setup_req, setup, done, error_timeout} !== 7'b0 || items_done !== '0) begin
            n_mismatched++;
            $display("FAIL reset_midrun: got req=%b setup=%b done=%b err=%b items=%0d want 0",
                     engine_setup_req, setup, done, error_timeout, items_done);
        end
        ctrl_start       = 1'b0;
        descriptor_valid = 1'b0;
        tick();
        areset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_compared++;
            if (engine_setup_req !== '0 || setup !== 1'b0 || done !== 1'b0) begin
                n_mismatched++;
                $display("FAIL reset_release%0d: got req=%b setup=%b done=%b want 0",
                         c, engine_setup_req, setup, done);
            end
        end
    endtask

    task automatic test_random_runs();
        for (int it = 0; it < 25; it++) begin
            int            ack_at [NE];
            int            last_ack;
            int            target;
            int            sum;
            bit            aborted;
            bit            reached;
            logic [NE-1:0] p;
            go_idle();
            last_ack = 0;
            for (int e = 0; e < NE; e++) begin
                ack_at[e] = $urandom_range(0, 9);
                if (ack_at[e] > last_ack) last_ack = ack_at[e];
            end
            ctrl_start = 1'b1;
            tick();
            // Each engine pulses its ack once; setup follows the last ack by 2 cycles.
            for (int c = 0; c <= last_ack + 1; c++) begin
                for (int e = 0; e < NE; e++) engine_setup_ack[e] = (ack_at[e] == c);
                tick();
                n_compared++;
                if (setup !== (c + 1 >= last_ack + 2)) begin
                    n_mismatched++;
                    $display("FAIL rnd%0d_setup c%0d: got %b want %b",
                             it, c + 1, setup, c + 1 >= last_ack + 2);
                end
            end
            engine_setup_ack = '0;
            for (int d = $urandom_range(0, 2); d > 0; d--) begin
                engine_done_item = NE'($urandom);
                tick();
            end
            target           = $urandom_range(0, 24);
            engine_done_item = NE'($urandom);
            run_start(target);
            n_compared++;
            if (items_done !== '0) begin
                n_mismatched++;
                $display("FAIL rnd%0d_entry: got %0d want 0", it, items_done);
            end
            sum     = 0;
            aborted = 1'b0;
            reached = 1'b0;
            for (int c = 0; c < 40; c++) begin
                p       = NE'($urandom);
                aborted = ($urandom_range(0, 19) == 0);
                if (aborted) descriptor_valid = 1'b0;
                engine_done_item = p;
                tick();
                sum = (sum + $countones(p) > target) ? target : sum + $countones(p);
                n_compared++;
                if (items_done !== CW'(sum)) begin
                    n_mismatched++;
                    $display("FAIL rnd%0d_count c%0d: got %0d want %0d",
                             it, c, items_done, sum);
                end
                if (aborted) break;
                if (sum == target) begin
                    reached = 1'b1;
                    break;
                end
            end
            engine_done_item = NE'($urandom);
            tick();
            n_compared++;
            if (done !== reached || items_done !== CW'(sum)) begin
                n_mismatched++;
                $display("FAIL rnd%0d_done: got done=%b items=%0d want %b/%0d",
                         it, done, items_done, reached, sum);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_setup_handshake();
        test_item_count();
        test_timeout();
        test_zero_and_saturate();
        test_abort_and_reset();
        test_random_runs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
